// File: rtl/jt12_slot_seq.sv
// jt12_slot_seq: operator-slot sequencer with a single-entry register write
// buffer released as a one-clock update strobe when its target slot comes up.
//
// Ports:
//   rst, clk            synchronous active-high reset, system clock
//   clk_en              advance one slot per high cycle
//   slot                current slot code {op[1:0], ch[2:0]}, ch in {0,1,2,4,5,6}
//   cur_ch, cur_op      linear channel 0..5 and operator 0..3 of slot
//   zero                high while slot == 0
//   wr_valid/wr_ready   register write handshake
//   wr_slot, wr_data    target slot and payload of the request
//   upd                 one-clock strobe, upd_data applies to upd_slot
//   upd_slot, upd_data  slot and payload of the last released write
//   err                 one-clock strobe, request dropped for an illegal ch code
module jt12_slot_seq #(
  parameter int DW = 8
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          clk_en,
  output logic [4:0]    slot,
  output logic [2:0]    cur_ch,
  output logic [1:0]    cur_op,
  output logic          zero,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [4:0]    wr_slot,
  input  logic [DW-1:0] wr_data,
  output logic          upd,
  output logic [4:0]    upd_slot,
  output logic [DW-1:0] upd_data,
  output logic          err
);

  logic [4:0]    pend_slot;
  logic [DW-1:0] pend_data;
  logic [2:0]    nch;
  logic [1:0]    nop;
  logic [4:0]    nxt;
  logic [2:0]    nlin;
  logic          take;
  logic          legal;
  logic          rel;

  // ch walks 0,1,2,4,5,6; the wrap from 6 bumps op
  always_comb begin
    nop = slot[4:3];
    nch = slot[2:0] + 3'd1;
    unique case (1'b1)
      (slot[2:0] == 3'd6): begin
        nch = 3'd0;
        nop = slot[4:3] + 2'd1;
      end
      (slot[2:0] == 3'd2): nch = 3'd4;
      default: ;
    endcase
  end

  assign nxt  = {nop, nch};
  assign nlin = (nch >= 3'd4) ? nch - 3'd1 : nch;

  // ch codes 3 and 7 both have the low two bits set
  assign legal = (wr_slot[1:0] != 2'b11);
  assign take  = wr_valid && wr_ready;

  // wr_ready low doubles as the pending flag; the compare uses the
  // pre-advance slot, so a write to the current slot waits a full frame
  assign rel = clk_en && !wr_ready && (slot == pend_slot);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot      <= 5'd0;
      cur_ch    <= 3'd0;
      cur_op    <= 2'd0;
      zero      <= 1'b1;
      wr_ready  <= 1'b1;
      pend_slot <= 5'd0;
      pend_data <= '0;
      upd       <= 1'b0;
      upd_slot  <= 5'd0;
      upd_data  <= '0;
      err       <= 1'b0;
    end else begin
      upd <= rel;
      err <= take && !legal;
      if (clk_en) begin
        slot   <= nxt;
        cur_ch <= nlin;
        cur_op <= nop;
        zero   <= (nxt == 5'd0);
      end
      if (rel) begin
        upd_slot <= pend_slot;
        upd_data <= pend_data;
        wr_ready <= 1'b1;
      end else if (take && legal) begin
        pend_slot <= wr_slot;
        pend_data <= wr_data;
        wr_ready  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/jt12_slot_seq.md
Name: jt12_slot_seq

Overview:
- Operator-slot sequencer for the FM datapath.
- Steps the 5-bit slot code {op[1:0], ch[2:0]} through the 24 slots (6 channels x 4 operators) once per frame, one step per clk_en tick.
- Holds one pending register write from the register interface and releases it as a one-clock update strobe exactly when its target slot is current, so per-slot register memories are written in sequence order.

Parameters:
DW, 8, data width of the buffered register write.

Ports:
- rst  input  1  synchronous reset, active-high
- clk  input  1  system clock
- clk_en  input  1  slot advance enable (one slot per high cycle)
- slot  output  5  current slot code {op,ch}; ch in {0,1,2,4,5,6}
- cur_ch  output  3  linear channel index 0..5 (ch minus 1 when ch>=4)
- cur_op  output  2  equals slot[4:3]
- zero  output  1  high while slot==5'd0
- wr_valid  input  1  register write request
- wr_ready  output  1  buffer empty, request can be taken
- wr_slot  input  5  target slot code of request
- wr_data  input  DW  request payload
- upd  output  1  one-clk strobe: payload applies to upd_slot
- upd_slot  output  5  slot the update belongs to
- upd_data  output  DW  payload delivered with upd
- err  output  1  one-clk strobe: request dropped (illegal ch code)

Behaviour:
- All outputs registered. Decided: one clock (clk); reset rst is synchronous, active-high.
- Reset values:
  - slot=0, cur_ch=0, cur_op=0, zero=1
  - wr_ready=1, upd=0, upd_slot=0, upd_data=0, err=0, pending flag cleared.
- Reset mid-operation discards any pending write without an upd.
- Slot advance, only on a clk_en=1 cycle:
  - ch 0->1->2->4->5->6, skipping 3 and 7.
  - At ch==6: ch->0 and op increments mod 4.
  - 5'b11110 -> 5'b00000 (frame wrap). Period is exactly 24 clk_en ticks.
  - clk_en=0 holds slot, cur_ch, cur_op and zero.
- cur_ch, cur_op and zero update on the same edge as slot and are always consistent with it.
- Handshake (independent of clk_en):
  - A request is taken when wr_valid && wr_ready.
  - Legal ch field (not 3, not 7): latch wr_slot and wr_data; wr_ready drops on the next cycle.
  - Illegal ch field: do not buffer; err=1 for one cycle; wr_ready stays 1.
- Release:
  - Occurs on a clk_en=1 cycle where pending && slot==pend_slot, with slot being the value before advancing.
  - Next cycle: upd=1, upd_slot=pend_slot, upd_data=pend_data; pending cleared and wr_ready=1.
  - upd is low every other cycle. upd_slot and upd_data hold their last values.
- Latency from acceptance to upd:
  - 1 to 24 clk_en ticks.
  - If the target is current on the acceptance cycle, release waits for the next frame. The compare uses the latched pending flag, which is not set on the acceptance cycle.
- wr_valid may be held while wr_ready=0. It is not taken until wr_ready returns. Back-to-back requests are therefore spaced by at least one release.
- If upd and a new acceptance fall on the same cycle boundary, the new entry is latched normally. The buffer is single-entry, so this occurs only on the cycle after release.

Test Plan:
- Reset, then clk_en=1 for 25 cycles:
  - slot sequence 00,01,02,04,05,06,08,...,1E,00.
  - cur_ch cycles 0..5.
  - zero high on ticks 0 and 24 only.
- clk_en alternating 1/0: slot advances only on enabled cycles and holds otherwise. 48 clk cycles give exactly one frame.
- At slot=02, write wr_slot=0x0D, data=0xA5:
  - wr_ready low until slot 0x0D is current.
  - upd=1 for one clk with upd_slot=0x0D, upd_data=0xA5; wr_ready=1 next.
- Write wr_slot equal to the current slot (0x05) on the acceptance cycle: upd occurs after 24 clk_en ticks, not immediately.
- Write wr_slot=0x03 or 0x1F: err pulses one clk, no upd ever, wr_ready stays 1.
- Pending write to 0x1E, then rst asserted for one cycle before the release: no upd. After reset slot=0, zero=1, wr_ready=1.
